// File: rtl/fb_pkg.sv
// fb_pkg: framebuffer geometry and arbiter FSM state encoding shared by the
// m_fb_arbiter slice.
package fb_pkg;

    localparam int FB_DEPTH = 1024;
    localparam int FB_AW    = 10;
    localparam int FB_DW    = 8;

    typedef enum logic [1:0] {
        S_SCAN     = 2'd0,
        S_CLIENT   = 2'd1,
        S_CLR_SCAN = 2'd2,
        S_CLR_WR   = 2'd3
    } fb_state_e;

    // Slots whose memory access belongs to the display scan port.
    function automatic logic is_scan_slot(input fb_state_e s);
        return (s == S_SCAN) || (s == S_CLR_SCAN);
    endfunction

endpackage

// File: rtl/m_rr_arb2.sv
// m_rr_arb2: two-way round-robin decision; on a tie the client that was not
// granted last wins (last=1 means client 1 was granted most recently).
module m_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[0] && (!req[1] || last)) begin
            gnt[0] = 1'b1;
        end else if (req[1]) begin
            gnt[1] = 1'b1;
        end
    end

endmodule

// File: rtl/m_fb_arbiter.sv
// m_fb_arbiter: time-slot arbiter sharing a single-port 1024x8 framebuffer
// between the display scan and two clients. Define FB_CLEAR_EN for the clear engine.
module m_fb_arbiter
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_btn,
    input  logic [FB_AW-1:0] scan_addr,
    output logic [FB_DW-1:0] scan_data,
    input  logic             req0,
    input  logic             we0,
    input  logic [FB_AW-1:0] addr0,
    input  logic [FB_DW-1:0] wdata0,
    output logic             gnt0,
    output logic [FB_DW-1:0] rdata0,
    output logic             rvalid0,
    input  logic             req1,
    input  logic             we1,
    input  logic [FB_AW-1:0] addr1,
    input  logic [FB_DW-1:0] wdata1,
    output logic             gnt1,
    output logic [FB_DW-1:0] rdata1,
    output logic             rvalid1,
    output logic [FB_AW-1:0] mem_addr,
    output logic             mem_we,
    output logic [FB_DW-1:0] mem_wdata,
    input  logic [FB_DW-1:0] mem_rdata,
    input  logic             clear_start,
    output logic             clear_busy
);

    fb_state_e        state_q, state_d;
    logic             last_q, last_d;
    logic             scan_pend_q, scan_pend_d;
    logic [1:0]       rd_pend_q, rd_pend_d;
    logic [1:0]       rvalid_q, rvalid_d;
    logic [FB_DW-1:0] scan_data_q, scan_data_d;
    logic [FB_DW-1:0] rdata0_q, rdata0_d;
    logic [FB_DW-1:0] rdata1_q, rdata1_d;
    logic [1:0]       arb_req, arb_gnt;
    logic             clr_go;
    logic             clr_last;
    logic             clr_wr;
    logic [FB_AW-1:0] clr_addr;

`ifdef FB_CLEAR_EN
    logic [FB_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic             clr_busy_q, clr_busy_d;

    always_comb begin
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLR_WR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
        end
        clr_busy_d = (state_d == S_CLR_SCAN) || (state_d == S_CLR_WR);
    end

    always_ff @(posedge clk) begin
        if (rst_btn) begin
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
        end else begin
            clr_cnt_q  <= clr_cnt_d;
            clr_busy_q <= clr_busy_d;
        end
    end

    assign clr_go     = (state_q == S_CLIENT) && clear_start && !clr_busy_q;
    assign clr_last   = (clr_cnt_q == FB_AW'(FB_DEPTH - 1));
    assign clr_wr     = (state_q == S_CLR_WR);
    assign clr_addr   = clr_cnt_q;
    assign clear_busy = clr_busy_q;
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign clr_go             = 1'b0;
    assign clr_last           = 1'b1;
    assign clr_wr             = 1'b0;
    assign clr_addr           = '0;
    assign clear_busy         = 1'b0;
`endif

    // Clients only compete in the client slot; reset suppresses any grant.
    assign arb_req = (state_q == S_CLIENT && !rst_btn) ? {req1, req0} : 2'b00;

    m_rr_arb2 u_rr_arb2 (
        .req  (arb_req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    assign gnt0 = arb_gnt[0];
    assign gnt1 = arb_gnt[1];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_SCAN:     state_d = S_CLIENT;
            S_CLIENT:   state_d = clr_go ? S_CLR_SCAN : S_SCAN;
            S_CLR_SCAN: state_d = S_CLR_WR;
            S_CLR_WR:   state_d = clr_last ? S_SCAN : S_CLR_SCAN;
            default:    state_d = S_SCAN;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (is_scan_slot(state_q)) begin
            mem_addr = scan_addr;
        end else if (arb_gnt[0]) begin
            mem_addr  = addr0;
            mem_we    = we0;
            mem_wdata = wdata0;
        end else if (arb_gnt[1]) begin
            mem_addr  = addr1;
            mem_we    = we1;
            mem_wdata = wdata1;
        end else if (clr_wr) begin
            mem_addr = clr_addr;
            mem_we   = 1'b1;
        end
        if (rst_btn) begin
            mem_we = 1'b0;
        end
    end

    // Read data lands one cycle after the slot; capture it on the cycle after that.
    always_comb begin
        last_d = last_q;
        if (arb_gnt[0]) begin
            last_d = 1'b0;
        end else if (arb_gnt[1]) begin
            last_d = 1'b1;
        end
        scan_pend_d = is_scan_slot(state_q);
        rd_pend_d   = arb_gnt & ~{we1, we0};
        rvalid_d    = rd_pend_q;
        scan_data_d = scan_pend_q  ? mem_rdata : scan_data_q;
        rdata0_d    = rd_pend_q[0] ? mem_rdata : rdata0_q;
        rdata1_d    = rd_pend_q[1] ? mem_rdata : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst_btn) begin
            state_q     <= S_SCAN;
            last_q      <= 1'b1;
            scan_pend_q <= 1'b0;
            rd_pend_q   <= '0;
            rvalid_q    <= '0;
            scan_data_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            scan_pend_q <= scan_pend_d;
            rd_pend_q   <= rd_pend_d;
            rvalid_q    <= rvalid_d;
            scan_data_q <= scan_data_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
        end
    end

    assign scan_data = scan_data_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign rvalid0   = rvalid_q[0];
    assign rvalid1   = rvalid_q[1];

endmodule

// File: doc/m_fb_arbiter.md
M_FB_ARBITER -- requirements
Module: m_fb_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  single clock; all logic on posedge.
REQ-002 SHALL have ports: rst_btn  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: scan_addr  in  10 / scan_data  out  8  display scan read port (pixel byte address / byte).
REQ-004 SHALL have ports, per client n in {0,1}: reqn  in  1 / wen  in  1 / addrn  in  10 / wdatan  in  8 / gntn  out  1 / rdatan  out  8 / rvalidn  out  1.
REQ-005 SHALL have ports: mem_addr  out  10 / mem_we  out  1 / mem_wdata  out  8 / mem_rdata  in  8  single-port 1024x8 framebuffer; synchronous read, 1-cycle latency.
REQ-006 SHALL have ports: clear_start  in  1 / clear_busy  out  1  hardware framebuffer clear.

Function
REQ-007 SHALL run a 4-state FSM: S_SCAN, S_CLIENT, S_CLR_SCAN, S_CLR_WR; each state lasts exactly one cycle.
REQ-008 SHALL transition S_SCAN->S_CLIENT and S_CLIENT->S_SCAN; S_CLR_SCAN->S_CLR_WR and S_CLR_WR->S_CLR_SCAN, or S_CLR_WR->S_SCAN after address 1023.
REQ-009 SHALL, in S_SCAN and S_CLR_SCAN, drive mem_addr=scan_addr, mem_we=0.
REQ-010 SHALL register mem_rdata into scan_data one cycle after each scan slot, i.e. 2 clocks after scan_addr is sampled; scan_data SHALL hold between updates.
REQ-011 SHALL, in S_CLIENT, grant at most one requester: only one req -> that one; both -> the one not granted last (round-robin); none -> mem_we=0, mem_addr=0.
REQ-012 SHALL assert gntn combinationally for exactly the S_CLIENT cycle, with mem_addr=addrn, mem_we=wen, mem_wdata=wdatan.
REQ-013 SHALL require clients to hold req/we/addr/wdata stable until gnt is seen; an ungranted request stays pending with no timeout.
REQ-014 SHALL, for a granted read (we=0), pulse rvalidn for one cycle 2 clocks after gnt, with rdatan=mem_rdata; rdatan SHALL hold until the next read completes.
REQ-015 SHALL generate no rvalid for writes; a write is visible to any read issued in a later slot.
REQ-016 SHALL make scan bandwidth fixed: one read every 2 cycles, independent of client load.
REQ-017 SHALL give each client worst-case grant latency of 4 cycles under contention (no clear active).

Reset
REQ-018 SHALL, while rst_btn=1, force state=S_SCAN, round-robin pointer=1 (client 0 wins first tie), clear counter=0, clear_busy=0, gnt0/1=0, rvalid0/1=0, scan_data=0, rdata0/1=0, mem_we=0.
REQ-019 SHALL discard reads in flight and abort an active clear on reset mid-operation; framebuffer contents are not restored.

Configuration
REQ-020 SHALL include the clear engine only when FB_CLEAR_EN is defined.
REQ-021 SHALL, with FB_CLEAR_EN, enter the clear on clear_start=1 sampled in S_CLIENT while not busy; clear_busy=1 from the next cycle. The FSM SHALL use S_CLR_SCAN/S_CLR_WR, writing 0x00 to addresses 0..1023 in S_CLR_WR.
REQ-022 SHALL, with FB_CLEAR_EN, keep clear_busy=1 for exactly 2048 cycles and grant no client while busy; clear_start while busy SHALL be ignored.
REQ-023 SHALL, without FB_CLEAR_EN, keep the ports, tie clear_busy=0, ignore clear_start, and leave S_CLR_* unreachable.

Structure
REQ-024 SHALL define in shared package fb_pkg: FB_DEPTH=1024, FB_AW=10, FB_DW=8, and the FSM state encoding.
REQ-025 SHALL place the two-way round-robin decision in sub-module m_rr_arb2 (inputs req[1:0], last; outputs gnt[1:0]).

Verification
REQ-026 SHALL cover: reset, then scan_addr=0x005 with mem holding 0x5A -> scan_data=0x5A 2 clocks after the S_SCAN sample, every other cycle.
REQ-027 SHALL cover: req0 write addr 0x010 data 0xA5, then req0 read 0x010 -> gnt0 in S_CLIENT; rvalid0 pulses 2 clocks later with rdata0=0xA5.
REQ-028 SHALL cover: req0 and req1 held high for 8 cycles -> grants alternate 0,1,0,1 on S_CLIENT cycles; scan slots are unaffected.
REQ-029 SHALL cover (FB_CLEAR_EN): clear_start with mem preloaded 0xFF -> clear_busy high 2048 cycles, req0 ungranted throughout, all 1024 bytes read back 0x00.
REQ-030 SHALL cover: rst_btn=1 one cycle after a read grant -> no rvalid; all outputs at REQ-018 values; next tie grants client 0.
REQ-031 SHALL cover (no FB_CLEAR_EN): clear_start=1 -> clear_busy stays 0 and client grants continue.
